// File: rtl/npu_sram_arbiter_if.sv
// rtl/npu_sram_arbiter_if.sv - one requester port of the NPU SRAM arbiter
interface npu_sram_arbiter_if #(
    parameter int AW = 16
);
    logic          req;
    logic [AW-1:0] addr;
    logic [3:0]    wren;
    logic [31:0]   wdata;
    logic          gnt;
    logic          rvalid;
    logic [31:0]   rdata;

    modport master (
        output req, addr, wren, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, wren, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/npu_sram_arbiter.sv
// rtl/npu_sram_arbiter.sv - weighted round-robin arbiter and zero-fill sequencer for one SRAM
module npu_sram_arbiter #(
    parameter int AW         = 16,
    parameter int MAX_BURST  = 4,
    parameter int INIT_CLEAR = 1
) (
    input  logic                clk,
    input  logic                rst,
    npu_sram_arbiter_if.slave   a_port,
    npu_sram_arbiter_if.slave   b_port,
    output logic                sram_cs,
    output logic [AW-1:0]       sram_addr,
    output logic [3:0]          sram_wren,
    output logic [31:0]         sram_wdata,
    input  logic [31:0]         sram_rdata,
    output logic                busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] LAST_ADDR = '1;

    typedef enum logic {ST_INIT, ST_ARB} state_t;
    localparam state_t RESET_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_ARB;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          owner_q, owner_d;      // 0 = port A, 1 = port B
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_port_q, rd_port_d;

    logic          grant_a, grant_b;
    logic [AW-1:0] sel_addr;
    logic [3:0]    sel_wren;
    logic [31:0]   sel_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            clr_addr_q <= '0;
            owner_q    <= 1'b0;
            cnt_q      <= '0;
            rd_pend_q  <= 1'b0;
            rd_port_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_port_q  <= rd_port_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        rd_pend_d  = 1'b0;
        rd_port_d  = rd_port_q;
        grant_a    = 1'b0;
        grant_b    = 1'b0;

        case (state_q)
            ST_INIT: begin
                clr_addr_d = clr_addr_q + AW'(1);
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                // Under contention the owner keeps the port until its burst allowance is spent.
                if (a_port.req && b_port.req) begin
                    if (cnt_q < CNT_MAX) begin
                        grant_a = !owner_q;
                        grant_b = owner_q;
                    end else begin
                        grant_a = owner_q;
                        grant_b = !owner_q;
                    end
                end else begin
                    grant_a = a_port.req;
                    grant_b = b_port.req;
                end
            end
        endcase

        sel_addr  = grant_b ? b_port.addr  : a_port.addr;
        sel_wren  = grant_b ? b_port.wren  : a_port.wren;
        sel_wdata = grant_b ? b_port.wdata : a_port.wdata;

        if (grant_a || grant_b) begin
            rd_pend_d = (sel_wren == 4'h0);
            rd_port_d = grant_b;
            if (grant_b == owner_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            end else begin
                owner_d = grant_b;
                cnt_d   = CNT_ONE;
            end
        end
    end

    always_comb begin
        a_port.gnt    = 1'b0;
        b_port.gnt    = 1'b0;
        a_port.rvalid = 1'b0;
        b_port.rvalid = 1'b0;
        a_port.rdata  = '0;
        b_port.rdata  = '0;
        sram_cs       = 1'b0;
        sram_addr     = '0;
        sram_wren     = 4'h0;
        sram_wdata    = '0;
        busy          = (state_q == ST_INIT);

        // Everything but busy is forced quiet while reset is held.
        if (!rst) begin
            if (state_q == ST_INIT) begin
                sram_cs   = 1'b1;
                sram_wren = 4'hF;
                sram_addr = clr_addr_q;
            end else if (grant_a || grant_b) begin
                sram_cs    = 1'b1;
                sram_addr  = sel_addr;
                sram_wren  = sel_wren;
                sram_wdata = sel_wdata;
            end
            a_port.gnt = grant_a;
            b_port.gnt = grant_b;
            if (rd_pend_q) begin
                if (rd_port_q) begin
                    b_port.rvalid = 1'b1;
                    b_port.rdata  = sram_rdata;
                end else begin
                    a_port.rvalid = 1'b1;
                    a_port.rdata  = sram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_npu_sram_arbiter.sv
// tb/tb_npu_sram_arbiter.sv - randomized and directed checks of npu_sram_arbiter against a behavioural model
module tb_npu_sram_arbiter;
    localparam int AW    = 5;
    localparam int MB    = 4;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    logic junk_fill;
    always #5 clk = ~clk;

    npu_sram_arbiter_if #(.AW(AW)) a_if ();
    npu_sram_arbiter_if #(.AW(AW)) b_if ();

    logic [1:0]    req;
    logic [AW-1:0] addr  [2];
    logic [3:0]    wren  [2];
    logic [31:0]   wdata [2];
    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [31:0]   rdata [2];

    assign a_if.req   = req[0];
    assign a_if.addr  = addr[0];
    assign a_if.wren  = wren[0];
    assign a_if.wdata = wdata[0];
    assign b_if.req   = req[1];
    assign b_if.addr  = addr[1];
    assign b_if.wren  = wren[1];
    assign b_if.wdata = wdata[1];
    assign gnt        = {b_if.gnt, a_if.gnt};
    assign rvalid     = {b_if.rvalid, a_if.rvalid};
    assign rdata[0]   = a_if.rdata;
    assign rdata[1]   = b_if.rdata;

    logic          sram_cs;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_wren;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;
    logic          busy;

    npu_sram_arbiter #(.AW(AW), .MAX_BURST(MB), .INIT_CLEAR(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_port     (a_if),
        .b_port     (b_if),
        .sram_cs    (sram_cs),
        .sram_addr  (sram_addr),
        .sram_wren  (sram_wren),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .busy       (busy)
    );

    // SRAM stand-in: 1-cycle read, byte-enable write; starts full of non-zero junk.
    logic [31:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (junk_fill) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= 32'hA5A5_0000 | i;
        end else if (sram_cs) begin
            if (sram_wren == 4'h0) sram_rdata <= sram_mem[sram_addr];
            else for (int i = 0; i < 4; i++)
                if (sram_wren[i]) sram_mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: fill countdown, current run (port and length), golden memory, pending read.
    int          init_left;
    int          run_port, run_len;
    logic [31:0] gold [DEPTH];
    bit          pend_v;
    int          pend_p;
    logic [31:0] pend_d;

    always @(negedge clk) begin
        int g;
        if (rst) begin
            chk("rst_gnt", gnt, 0);
            chk("rst_rvalid", rvalid, 0);
            chk("rst_rdata_a", rdata[0], 0);
            chk("rst_rdata_b", rdata[1], 0);
            chk("rst_cs", sram_cs, 0);
            chk("rst_addr", sram_addr, 0);
            chk("rst_wren", sram_wren, 0);
            chk("rst_wdata", sram_wdata, 0);
            chk("rst_busy", busy, 1);
            init_left = DEPTH;
            run_port  = 0;
            run_len   = 0;
            pend_v    = 0;
            for (int i = 0; i < DEPTH; i++) gold[i] = '0;
        end else if (init_left > 0) begin
            chk("init_cs", sram_cs, 1);
            chk("init_addr", sram_addr, DEPTH - init_left);
            chk("init_wren", sram_wren, 4'hF);
            chk("init_wdata", sram_wdata, 0);
            chk("init_gnt", gnt, 0);
            chk("init_rvalid", rvalid, 0);
            chk("init_busy", busy, 1);
            init_left--;
        end else begin
            g = -1;
            if (req == 2'b11) g = (run_len < MB) ? run_port : 1 - run_port;
            else if (req[0]) g = 0;
            else if (req[1]) g = 1;
            chk("arb_gnt", gnt, {30'd0, g == 1, g == 0});
            chk("arb_busy", busy, 0);
            chk("arb_cs", sram_cs, g >= 0);
            chk("arb_addr", sram_addr, (g >= 0) ? addr[g] : '0);
            chk("arb_wren", sram_wren, (g >= 0) ? wren[g] : '0);
            chk("arb_wdata", sram_wdata, (g >= 0) ? wdata[g] : '0);
            chk("rvalid", rvalid, pend_v ? (pend_p == 1 ? 2 : 1) : 0);
            chk("rdata_a", rdata[0], (pend_v && pend_p == 0) ? pend_d : '0);
            chk("rdata_b", rdata[1], (pend_v && pend_p == 1) ? pend_d : '0);
            pend_v = 0;
            if (g >= 0) begin
                if (wren[g] == 4'h0) begin
                    pend_v = 1;
                    pend_p = g;
                    pend_d = gold[addr[g]];
                end else begin
                    for (int i = 0; i < 4; i++)
                        if (wren[g][i]) gold[addr[g]][8*i +: 8] = wdata[g][8*i +: 8];
                end
                if (g == run_port) run_len++;
                else begin
                    run_port = g;
                    run_len  = 1;
                end
            end
        end
    end

    task automatic access(input int p, input int a, input logic [3:0] we, input logic [31:0] wd,
                          output int lat);
        req[p]   = 1'b1;
        addr[p]  = AW'(a);
        wren[p]  = we;
        wdata[p] = wd;
        lat = 0;
        @(negedge clk);
        while (!gnt[p] && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        chk("access_gnt", gnt[p], 1);
        @(posedge clk); #1;
        req[p] = 1'b0;
    endtask

    task automatic read_expect(input int p, input int a, input logic [31:0] exp);
        int lat;
        access(p, a, 4'h0, 32'h0, lat);
        chk("read_gnt_latency", lat, 0);
        @(negedge clk);
        chk("read_rvalid", rvalid[p], 1);
        chk("read_rdata", rdata[p], exp);
        chk("read_other_rvalid", rvalid[1-p], 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_init(input string nm);
        int n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk(nm, n, DEPTH);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [11:0] patb;
        logic [1:0]  took;
        int r;

        req = '0;
        for (int p = 0; p < 2; p++) begin
            addr[p] = '0; wren[p] = '0; wdata[p] = '0;
        end
        rst = 1'b1;
        junk_fill = 1'b1;
        repeat (2) @(posedge clk);
        #1 junk_fill = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 1);
        chk("reset_cs", sram_cs, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        wait_init("init_len");

        // Contention from owner=A, cnt=0 with MAX_BURST=4
        @(posedge clk); #1;
        req = 2'b11;
        addr[0] = 7; addr[1] = 7; wren[0] = 0; wren[1] = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            patb[i] = gnt[1];
            chk("t3_one_hot", gnt[0] ^ gnt[1], 1);
            @(posedge clk); #1;
        end
        req = '0;
        chk("t3_pattern", patb, 12'h0F0);

        read_expect(1, 7, 32'h0);

        access(0, 16, 4'hF, 32'hDEAD_BEEF, lat);
        read_expect(0, 16, 32'hDEAD_BEEF);

        access(0, 3, 4'hF, 32'h1122_3344, lat);
        access(1, 3, 4'b0100, 32'h00AA_0000, lat);
        read_expect(0, 3, 32'h11AA_3344);

        access(1, 1, 4'hF, 32'h1111_0001, lat);
        access(0, 2, 4'hF, 32'h2222_0002, lat);
        access(1, 3, 4'hF, 32'h3333_0003, lat);
        req = 2'b01; addr[0] = 1; wren[0] = 0;
        @(negedge clk);
        chk("t5_gnt_a1", gnt, 2'b01);
        @(posedge clk); #1;
        req = 2'b10; addr[1] = 2; wren[1] = 0;
        @(negedge clk);
        chk("t5_gnt_b2", gnt, 2'b10);
        chk("t5_rv_a1", rvalid, 2'b01);
        chk("t5_rd_a1", rdata[0], 32'h1111_0001);
        @(posedge clk); #1;
        req = 2'b01; addr[0] = 3;
        @(negedge clk);
        chk("t5_rv_b2", rvalid, 2'b10);
        chk("t5_rd_b2", rdata[1], 32'h2222_0002);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        chk("t5_rv_a3", rvalid, 2'b01);
        chk("t5_rd_a3", rdata[0], 32'h3333_0003);
        @(posedge clk); #1;

        // Random traffic: requests held until granted, then re-rolled.
        took = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req[p] || took[p]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        req[p]   = 1'b1;
                        addr[p]  = AW'($urandom_range(0, DEPTH - 1));
                        r        = $urandom_range(0, 3);
                        wren[p]  = (r < 2) ? 4'h0 : (r == 2) ? 4'hF : 4'($urandom_range(0, 15));
                        wdata[p] = $urandom;
                    end else begin
                        req[p] = 1'b0;
                    end
                end
            end
            @(negedge clk);
            took = gnt;
            @(posedge clk); #1;
        end
        req = '0;

        // Reset with a read pending, then again mid-fill at clr_addr=9
        req = 2'b01; addr[0] = 2; wren[0] = 0;
        @(negedge clk);
        chk("t6_gnt", gnt, 2'b01);
        @(posedge clk); #1;
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_no_stale_rvalid", rvalid, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_busy", busy, 1);
        chk("t6_rst_cs", sram_cs, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_restart_addr", sram_addr, 0);
        chk("t6_restart_cs", sram_cs, 1);
        wait_init("t6_init_len");
        @(posedge clk); #1;
        read_expect(1, 16, 32'h0);
        read_expect(0, 3, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
